// File: rtl/pong_pkg.sv
// Shared playfield constants, FSM state type and winner encodings for the
// pong score keeper.
package pong_pkg;

  localparam int X_W     = 6;
  localparam int Y_W     = 5;
  localparam int FIELD_W = 64;
  localparam int FIELD_H = 32;

  localparam int LEFT_COL  = 1;
  localparam int RIGHT_COL = 62;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_PLAY       = 2'd1,
    ST_POINT_HOLD = 2'd2,
    ST_GAME_OVER  = 2'd3
  } state_e;

  localparam logic [1:0] WIN_NONE  = 2'b00;
  localparam logic [1:0] WIN_LEFT  = 2'b01;
  localparam logic [1:0] WIN_RIGHT = 2'b10;

endpackage

// File: rtl/paddle_hit_check.sv
// Combinational paddle span test: hit when paddle_y <= ball_y <= paddle_y+PADDLE_H-1.
module paddle_hit_check
  import pong_pkg::*;
#(
  parameter int PADDLE_H = 6
) (
  input  logic [Y_W-1:0] ball_y,
  input  logic [Y_W-1:0] paddle_y,
  output logic           hit
);

  localparam int             EXT_W = Y_W + 1;
  localparam logic [EXT_W-1:0] SPAN = EXT_W'(PADDLE_H - 1);

  logic [EXT_W-1:0] ball_ext;
  logic [EXT_W-1:0] top_ext;
  logic [EXT_W-1:0] bot_ext;

  // One extra bit keeps the bottom edge from wrapping; rows past 31 simply never match.
  assign ball_ext = {1'b0, ball_y};
  assign top_ext  = {1'b0, paddle_y};
  assign bot_ext  = top_ext + SPAN;
  assign hit      = (ball_ext >= top_ext) && (ball_ext <= bot_ext);

endmodule

// File: rtl/pong_score_keeper.sv
// Pong score keeper: detects paddle hits/misses at the goal columns, keeps the
// scores and sequences serve, point hold and game over.
module pong_score_keeper #(
  parameter int PADDLE_H    = 6,
  parameter int WIN_SCORE   = 9,
  parameter int SCORE_W     = 4,
  parameter int LEFT_COL    = pong_pkg::LEFT_COL,
  parameter int RIGHT_COL   = pong_pkg::RIGHT_COL,
  parameter int HOLD_CYCLES = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         ball_x,
  input  logic [4:0]         ball_y,
  input  logic               ball_move,
  input  logic [4:0]         paddle_l_y,
  input  logic [4:0]         paddle_r_y,
  input  logic               start,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic               hit_l,
  output logic               hit_r,
  output logic               point_l,
  output logic               point_r,
  output logic               serve_req,
  output logic               game_active,
  output logic [1:0]         winner
);

  import pong_pkg::*;

  localparam int                 HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0]  HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [SCORE_W-1:0] WIN_VAL   = SCORE_W'(WIN_SCORE);
  localparam logic [X_W-1:0]     LCOL      = X_W'(LEFT_COL);
  localparam logic [X_W-1:0]     RCOL      = X_W'(RIGHT_COL);

  state_e              state_q, state_d;
  logic [SCORE_W-1:0]  score_l_q, score_l_d;
  logic [SCORE_W-1:0]  score_r_q, score_r_d;
  logic                hit_l_q, hit_l_d;
  logic                hit_r_q, hit_r_d;
  logic                point_l_q, point_l_d;
  logic                point_r_q, point_r_d;
  logic                serve_req_q, serve_req_d;
  logic [1:0]          winner_q, winner_d;
  logic                armed_q, armed_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;

  logic paddle_l_hit;
  logic paddle_r_hit;
  logic contact_l;
  logic contact_r;
  logic mid_field;

  paddle_hit_check #(.PADDLE_H(PADDLE_H)) u_hit_l (
    .ball_y   (ball_y),
    .paddle_y (paddle_l_y),
    .hit      (paddle_l_hit)
  );

  paddle_hit_check #(.PADDLE_H(PADDLE_H)) u_hit_r (
    .ball_y   (ball_y),
    .paddle_y (paddle_r_y),
    .hit      (paddle_r_hit)
  );

  assign contact_l = (ball_x <= LCOL);
  assign contact_r = (ball_x >= RCOL);
  assign mid_field = (ball_x > LCOL) && (ball_x < RCOL);

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (s >= WIN_VAL) ? WIN_VAL : s + 1'b1;
  endfunction

  always_comb begin
    state_d     = state_q;
    score_l_d   = score_l_q;
    score_r_d   = score_r_q;
    winner_d    = winner_q;
    armed_d     = armed_q;
    hold_d      = hold_q;
    hit_l_d     = 1'b0;
    hit_r_d     = 1'b0;
    point_l_d   = 1'b0;
    point_r_d   = 1'b0;
    serve_req_d = 1'b0;

    case (state_q)
      ST_IDLE, ST_GAME_OVER: begin
        if (start) begin
          score_l_d   = '0;
          score_r_d   = '0;
          winner_d    = WIN_NONE;
          serve_req_d = 1'b1;
          armed_d     = 1'b1;
          state_d     = ST_PLAY;
        end
      end

      ST_PLAY: begin
        // Contacts are judged on the position held before this move takes effect.
        if (ball_move) begin
          if (armed_q && contact_l) begin
            armed_d = 1'b0;
            if (paddle_l_hit) begin
              hit_l_d = 1'b1;
            end else begin
              score_r_d = sat_inc(score_r_q);
              point_r_d = 1'b1;
              hold_d    = HOLD_LOAD;
              state_d   = ST_POINT_HOLD;
            end
          end else if (armed_q && contact_r) begin
            armed_d = 1'b0;
            if (paddle_r_hit) begin
              hit_r_d = 1'b1;
            end else begin
              score_l_d = sat_inc(score_l_q);
              point_l_d = 1'b1;
              hold_d    = HOLD_LOAD;
              state_d   = ST_POINT_HOLD;
            end
          end else if (mid_field) begin
            armed_d = 1'b1;
          end
        end
      end

      ST_POINT_HOLD: begin
        if (hold_q == '0) begin
          if (score_l_q == WIN_VAL) begin
            winner_d = WIN_LEFT;
            state_d  = ST_GAME_OVER;
          end else if (score_r_q == WIN_VAL) begin
            winner_d = WIN_RIGHT;
            state_d  = ST_GAME_OVER;
          end else begin
            serve_req_d = 1'b1;
            armed_d     = 1'b1;
            state_d     = ST_PLAY;
          end
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      score_l_q   <= '0;
      score_r_q   <= '0;
      hit_l_q     <= 1'b0;
      hit_r_q     <= 1'b0;
      point_l_q   <= 1'b0;
      point_r_q   <= 1'b0;
      serve_req_q <= 1'b0;
      winner_q    <= WIN_NONE;
      armed_q     <= 1'b1;
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      score_l_q   <= score_l_d;
      score_r_q   <= score_r_d;
      hit_l_q     <= hit_l_d;
      hit_r_q     <= hit_r_d;
      point_l_q   <= point_l_d;
      point_r_q   <= point_r_d;
      serve_req_q <= serve_req_d;
      winner_q    <= winner_d;
      armed_q     <= armed_d;
      hold_q      <= hold_d;
    end
  end

  assign score_l     = score_l_q;
  assign score_r     = score_r_q;
  assign hit_l       = hit_l_q;
  assign hit_r       = hit_r_q;
  assign point_l     = point_l_q;
  assign point_r     = point_r_q;
  assign serve_req   = serve_req_q;
  assign winner      = winner_q;
  assign game_active = (state_q == ST_PLAY) || (state_q == ST_POINT_HOLD);

endmodule
